cnot_debounce_bank: RTL and testbench
=====================================

// Module: cnot_debounce_bank
// PURPOSE
// - WIDTH-channel controlled-NOT bank: each output is the conditioned input XOR a per-channel invert mask.
// - Next generation of the single-bit registered-less CNOT gate.
// - Adds input synchronisation, per-channel debounce, a registered output, a toggle (T-latch) mode and change pulses.
// - Sits between raw board inputs (buttons, switches) and user logic.
// PARAMETERS
// WIDTH            4   number of independent channels
// SYNC_STAGES      2   synchroniser flops per channel (>=2)
// DEBOUNCE_CYCLES  16  consecutive stable cycles needed to accept a new level (>=1)
// PORTS
// clk        in   1      system clock, all logic on rising edge
// rst        in   1      asynchronous, active-high reset
// din        in   WIDTH  raw asynchronous inputs
// inv_mask   in   WIDTH  per-channel invert control (1 = NOT, 0 = buffer); synchronous to clk
// mode       in   2      00 BYPASS, 01 DEBOUNCE, 10 TOGGLE, 11 reserved (behaves as DEBOUNCE)
// dout       out  WIDTH  registered conditioned outputs
// change     out  WIDTH  one-cycle pulse when the matching dout bit changes
// stable     out  WIDTH  1 when the channel's debounce counter is idle (no pending transition)
// BEHAVIOUR
// - Reset (async assert, sync release by clk): sync chain, debounced level deb, toggle state tq, counters, dout, change = 0.
//   - stable resets to all 1s.
// - Synchroniser: s = din delayed SYNC_STAGES clocks.
// - Debounce, per channel, counter cnt of width $clog2(DEBOUNCE_CYCLES+1):
//   - s == deb: cnt <= 0, stable = 1.
//   - s != deb and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1, stable = 0.
//   - s != deb and cnt == DEBOUNCE_CYCLES-1: deb <= s, cnt <= 0.
//   - A glitch shorter than DEBOUNCE_CYCLES resets cnt and never reaches deb.
// - Source level src per mode (mode sampled every cycle):
//   - BYPASS: src = s (debounce bypassed; counters keep running).
//   - DEBOUNCE: src = deb.
//   - TOGGLE: tq <= ~tq on each cycle where deb rises (0->1); src = tq.
// - tq updates in every mode, so switching to TOGGLE shows the current tq.
// - Output register: dout <= src ^ inv_mask, every cycle.
// - change <= dout_next ^ dout, i.e. it pulses in the same cycle dout takes its new value.
// - Latency from a din edge to dout:
//   - BYPASS: SYNC_STAGES+1 clocks.
//   - DEBOUNCE and TOGGLE: SYNC_STAGES+DEBOUNCE_CYCLES+1 clocks.
// - inv_mask or mode change: visible on dout 1 clock later; change pulses if dout flips.
// - Simultaneous events: channels are fully independent; any combination of change bits may assert together.
// - Reset mid-debounce discards the pending transition; no change pulse is emitted by reset itself.
// - After release with din held high: dout follows the normal latency with a single change pulse.
// STRUCTURE
// - Shared package cnot_pkg:
//   - mode localparams MODE_BYPASS=2'd0, MODE_DEBOUNCE=2'd1, MODE_TOGGLE=2'd2.
//   - counter-width function.
// - Sub-module cnot_debounce_chan: one channel (sync chain, counter, deb, tq, dout and change flops).
// - Top level: generate loop of WIDTH instances sharing mode.
// TESTING (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=16)
// 1 Reset.
//   - Stimulus: rst high 3 clks, din=4'hF, mask=0, mode=DEBOUNCE.
//   - Response: dout=0 during reset; dout=4'hF exactly 19 clks after release; one change=4'hF pulse.
// 2 Glitch rejection.
//   - Stimulus: din[0] pulsed high for 15 clks.
//   - Response: dout[0] stays 0, change[0] never asserts, stable[0]=0 during the pulse then 1.
// 3 CNOT.
//   - Stimulus: mode=BYPASS, din=4'b1010, mask=4'b0110.
//   - Response: dout=4'b1100 3 clks after din.
//   - Then toggle mask[3]: dout[3] flips 1 clk later with change=4'b1000.
// 4 Toggle.
//   - Stimulus: mode=TOGGLE, three clean 40-clk press/release cycles on din[2].
//   - Response: dout[2] goes 1,0,1; each flip 19 clks after the rising edge; no flip on release.
// 5 Reset mid-debounce.
//   - Stimulus: din[1] high, rst asserted after 10 clks.
//   - Response: all outputs 0 immediately (async); dout[1]=1 19 clks after release.
// 6 Simultaneous.
//   - Stimulus: all din bits rise in the same clk.
//   - Response: change=4'hF in one single cycle.

Source files
------------

// File: rtl/cnot_pkg.sv
// Shared definitions for the CNOT debounce bank: mode encodings and counter sizing.
package cnot_pkg;

    localparam logic [1:0] MODE_BYPASS   = 2'd0;
    localparam logic [1:0] MODE_DEBOUNCE = 2'd1;
    localparam logic [1:0] MODE_TOGGLE   = 2'd2;

    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/cnot_debounce_chan.sv
// One CNOT channel: synchroniser, debounce counter, toggle latch and registered
// output with change pulse.
module cnot_debounce_chan
    import cnot_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       inv_mask,
    input  logic [1:0] mode,
    output logic       dout,
    output logic       change,
    output logic       stable
);

    localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;
    logic                   deb;
    logic                   tq;
    logic                   accept;
    logic                   src;
    logic                   dout_next;

    assign s      = sync[SYNC_STAGES-1];
    assign accept = (s != deb) && (cnt == CNT_LAST);

    always_comb begin
        src = deb;
        case (mode)
            MODE_BYPASS: src = s;
            MODE_TOGGLE: src = tq;
            default:     src = deb;
        endcase
    end

    assign dout_next = src ^ inv_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            cnt    <= '0;
            deb    <= 1'b0;
            tq     <= 1'b0;
            stable <= 1'b1;
            dout   <= 1'b0;
            change <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            if (s == deb) begin
                cnt    <= '0;
                stable <= 1'b1;
            end else if (accept) begin
                deb    <= s;
                cnt    <= '0;
                stable <= 1'b1;
            end else begin
                cnt    <= cnt + CW'(1);
                stable <= 1'b0;
            end
            // tq flips on the same edge deb is accepted high, regardless of mode
            if (accept && s)
                tq <= ~tq;
            dout   <= dout_next;
            change <= dout_next ^ dout;
        end
    end

endmodule

// File: rtl/cnot_debounce_bank.sv
// WIDTH-channel controlled-NOT bank with synchronised, debounced inputs;
// each channel is independent and all share the mode select.
module cnot_debounce_bank
    import cnot_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] inv_mask,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] change,
    output logic [WIDTH-1:0] stable
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        cnot_debounce_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .din      (din[i]),
            .inv_mask (inv_mask[i]),
            .mode     (mode),
            .dout     (dout[i]),
            .change   (change[i]),
            .stable   (stable[i])
        );
    end

endmodule

// File: tb/tb_cnot_debounce_bank.sv
// Scoreboard bench for cnot_debounce_bank: expectations are queued with a target
// cycle when stimulus is driven and compared on the falling edge of that cycle.
module tb_cnot_debounce_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic [3:0] inv_mask;
    logic [1:0] mode;
    logic [3:0] dout;
    logic [3:0] change;
    logic [3:0] stable;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        string      tag;
        int         sig;   // 0 dout, 1 change, 2 stable
        logic [3:0] m;
        logic [3:0] e;
    } exp_t;

    exp_t sb[$];

    cnot_debounce_bank #(
        .WIDTH           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .inv_mask (inv_mask),
        .mode     (mode),
        .dout     (dout),
        .change   (change),
        .stable   (stable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_at(input int c, input string tag, input int sig,
                             input logic [3:0] m, input logic [3:0] e);
        exp_t x;
        x.cyc = c;
        x.tag = tag;
        x.sig = sig;
        x.m   = m;
        x.e   = e;
        sb.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    exp_t       keep[$];
    logic [3:0] got;

    always @(negedge clk) begin
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc <= cyc) begin
                case (sb[i].sig)
                    0:       got = dout;
                    1:       got = change;
                    default: got = stable;
                endcase
                chk(sb[i].tag, {28'd0, got & sb[i].m}, {28'd0, sb[i].e & sb[i].m});
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        logic [3:0] nv;
        logic [3:0] pv;

        // 1: reset with inputs high
        rst      = 1'b1;
        din      = 4'hF;
        inv_mask = 4'h0;
        mode     = 2'b01;
        step(3);
        chk("rst_dout",   {28'd0, dout},   32'h0);
        chk("rst_change", {28'd0, change}, 32'h0);
        chk("rst_stable", {28'd0, stable}, 32'hF);
        rst = 1'b0;
        t = cyc;
        expect_at(t + 18, "t1_dout_pre",  0, 4'hF, 4'h0);
        expect_at(t + 19, "t1_dout",      0, 4'hF, 4'hF);
        expect_at(t + 19, "t1_change",    1, 4'hF, 4'hF);
        for (int k = 1; k <= 24; k++)
            if (k != 19) expect_at(t + k, "t1_no_change", 1, 4'hF, 4'h0);
        step(25);

        // inputs low again before the glitch test
        din = 4'h0;
        t = cyc;
        expect_at(t + 18, "t2_fall_pre", 0, 4'hF, 4'hF);
        expect_at(t + 19, "t2_fall",     0, 4'hF, 4'h0);
        expect_at(t + 19, "t2_fall_chg", 1, 4'hF, 4'hF);
        step(22);

        // 2: 15-cycle glitch on din[0]
        din[0] = 1'b1;
        t = cyc;
        for (int k = 1; k <= 40; k++) begin
            expect_at(t + k, "t2_glitch_dout", 0, 4'b0001, 4'b0000);
            expect_at(t + k, "t2_glitch_chg",  1, 4'b0001, 4'b0000);
        end
        expect_at(t + 2, "t2_stable_before", 2, 4'b0001, 4'b0001);
        for (int k = 3; k <= 17; k++)
            expect_at(t + k, "t2_stable_busy", 2, 4'b0001, 4'b0000);
        expect_at(t + 18, "t2_stable_after", 2, 4'b0001, 4'b0001);
        step(15);
        din[0] = 1'b0;
        step(26);

        // 3: CNOT in bypass
        mode     = 2'b00;
        din      = 4'b1010;
        inv_mask = 4'b0110;
        t = cyc;
        expect_at(t + 1, "t3_mask_only", 0, 4'hF, 4'b0110);
        expect_at(t + 2, "t3_pre",       0, 4'hF, 4'b0110);
        expect_at(t + 3, "t3_cnot",      0, 4'hF, 4'b1100);
        expect_at(t + 3, "t3_cnot_chg",  1, 4'hF, 4'b1010);
        step(5);
        inv_mask = 4'b1110;
        t = cyc;
        expect_at(t + 1, "t3_mask3",      0, 4'hF, 4'b0100);
        expect_at(t + 1, "t3_mask3_chg",  1, 4'hF, 4'b1000);
        expect_at(t + 2, "t3_mask3_hold", 1, 4'hF, 4'b0000);
        step(5);

        // 4: toggle mode from a clean reset
        rst      = 1'b1;
        din      = 4'h0;
        inv_mask = 4'h0;
        mode     = 2'b10;
        step(2);
        rst = 1'b0;
        step(25);
        expect_at(cyc + 1, "t4_start", 0, 4'hF, 4'h0);
        for (int p = 0; p < 3; p++) begin
            nv = (p % 2 == 0) ? 4'b0100 : 4'b0000;
            pv = nv ^ 4'b0100;
            din[2] = 1'b1;
            t = cyc;
            expect_at(t + 18, "t4_press_pre", 0, 4'b0100, pv);
            expect_at(t + 18, "t4_press_nochg", 1, 4'b0100, 4'b0000);
            expect_at(t + 19, "t4_press_flip", 0, 4'b0100, nv);
            expect_at(t + 19, "t4_press_chg", 1, 4'b0100, 4'b0100);
            step(40);
            din[2] = 1'b0;
            t = cyc;
            for (int k = 1; k <= 39; k++) begin
                expect_at(t + k, "t4_release_dout", 0, 4'b0100, nv);
                expect_at(t + k, "t4_release_chg",  1, 4'b0100, 4'b0000);
            end
            step(40);
        end

        // 5: reset in the middle of a debounce
        din  = 4'b0010;
        mode = 2'b01;
        t = cyc;
        expect_at(t + 1, "t5_mode_dout", 0, 4'hF, 4'b0000);
        expect_at(t + 1, "t5_mode_chg",  1, 4'hF, 4'b0100);
        expect_at(t + 9, "t5_pending",   2, 4'b0010, 4'b0000);
        step(10);
        rst = 1'b1;
        #1;
        chk("t5_async_dout",   {28'd0, dout},   32'h0);
        chk("t5_async_change", {28'd0, change}, 32'h0);
        chk("t5_async_stable", {28'd0, stable}, 32'hF);
        step(2);
        rst = 1'b0;
        t = cyc;
        expect_at(t + 18, "t5_dout_pre",  0, 4'hF, 4'b0000);
        expect_at(t + 18, "t5_chg_pre",   1, 4'hF, 4'b0000);
        expect_at(t + 19, "t5_dout",      0, 4'hF, 4'b0010);
        expect_at(t + 19, "t5_chg",       1, 4'hF, 4'b0010);
        expect_at(t + 20, "t5_chg_after", 1, 4'hF, 4'b0000);
        step(25);

        // 6: all channels rise together
        din = 4'h0;
        step(25);
        din = 4'hF;
        t = cyc;
        expect_at(t + 18, "t6_chg_pre",   1, 4'hF, 4'h0);
        expect_at(t + 19, "t6_dout",      0, 4'hF, 4'hF);
        expect_at(t + 19, "t6_chg",       1, 4'hF, 4'hF);
        expect_at(t + 20, "t6_chg_after", 1, 4'hF, 4'h0);
        step(25);

        chk("sb_drain", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
